// File: rtl/alu_exec_if.sv
// alu_exec_if: opcode package plus the RS-issue / ALU-CDB bus of the execute stage
package alu_exec_pkg;
  localparam int OPT_W = 6;
  localparam int ROB_W = 4;
  typedef enum logic [OPT_W-1:0] {
    OPT_NONE, OPT_LUI, OPT_AUIPC, OPT_JAL, OPT_JALR,
    OPT_BEQ, OPT_BNE, OPT_BLT, OPT_BGE, OPT_BLTU, OPT_BGEU,
    OPT_ADDI, OPT_SLTI, OPT_SLTIU, OPT_XORI, OPT_ORI, OPT_ANDI, OPT_SLLI, OPT_SRLI, OPT_SRAI,
    OPT_ADD, OPT_SUB, OPT_SLL, OPT_SLT, OPT_SLTU, OPT_XOR, OPT_SRL, OPT_SRA, OPT_OR, OPT_AND
  } opt_e;
endpackage

interface alu_exec_if;
  import alu_exec_pkg::*;
  logic             alu_rb;
  logic             alu_ena;
  logic [OPT_W-1:0] alu_opt;
  logic [31:0]      alu_val1;
  logic [31:0]      alu_val2;
  logic [31:0]      alu_imm;
  logic [ROB_W-1:0] alu_rob_idx;
  logic             cdb_alu_valid;
  logic [ROB_W-1:0] cdb_alu_src;
  logic [31:0]      cdb_alu_val;
  logic             cdb_alu_jump;
  logic [31:0]      cdb_alu_tgt;
  modport master (output alu_rb, alu_ena, alu_opt, alu_val1, alu_val2, alu_imm, alu_rob_idx,
                  input cdb_alu_valid, cdb_alu_src, cdb_alu_val, cdb_alu_jump, cdb_alu_tgt);
  modport slave (input alu_rb, alu_ena, alu_opt, alu_val1, alu_val2, alu_imm, alu_rob_idx,
                 output cdb_alu_valid, cdb_alu_src, cdb_alu_val, cdb_alu_jump, cdb_alu_tgt);
endinterface

// File: rtl/alu_exec.sv
// alu_exec: pipelined RV32I integer execute stage broadcasting on the ALU CDB channel
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int PIPE_STAGES = 1
) (
  input logic        clk,
  input logic        rst,
  input logic        rdy,
  alu_exec_if.slave  b
);
  typedef struct packed {
    logic             v;
    logic [ROB_W-1:0] src;
    logic [31:0]      val;
    logic             jump;
    logic [31:0]      tgt;
  } cdb_t;
  cdb_t st [PIPE_STAGES];
  cdb_t nxt;
  logic [31:0] x, y, res, tgt;
  logic        jmp, acc;
  assign x = b.alu_val1;
  assign y = b.alu_opt inside {[OPT_ADDI:OPT_SRAI]} ? b.alu_imm : b.alu_val2;
  always_comb begin
    res = '0;
    jmp = 1'b0;
    tgt = '0;
    case (b.alu_opt)
      OPT_LUI:             res = b.alu_imm;
      OPT_AUIPC:           res = x + b.alu_imm;
      OPT_JAL:             begin res = x + 32'd4; jmp = 1'b1; end
      OPT_JALR:            begin res = b.alu_val2 + 32'd4; jmp = 1'b1; tgt = (x + b.alu_imm) & ~32'd1; end
      OPT_BEQ:             jmp = x == y;
      OPT_BNE:             jmp = x != y;
      OPT_BLT:             jmp = $signed(x) < $signed(y);
      OPT_BGE:             jmp = $signed(x) >= $signed(y);
      OPT_BLTU:            jmp = x < y;
      OPT_BGEU:            jmp = x >= y;
      OPT_ADD, OPT_ADDI:   res = x + y;
      OPT_SUB:             res = x - y;
      OPT_SLL, OPT_SLLI:   res = x << y[4:0];
      OPT_SLT, OPT_SLTI:   res = {31'd0, $signed(x) < $signed(y)};
      OPT_SLTU, OPT_SLTIU: res = {31'd0, x < y};
      OPT_XOR, OPT_XORI:   res = x ^ y;
      OPT_SRL, OPT_SRLI:   res = x >> y[4:0];
      OPT_SRA, OPT_SRAI:   res = $signed(x) >>> y[4:0];
      OPT_OR, OPT_ORI:     res = x | y;
      OPT_AND, OPT_ANDI:   res = x & y;
      default:             res = '0;
    endcase
  end
  // untagged ops are dropped; idle slots carry all-zero payload so outputs need no gating
  assign acc = b.alu_ena && b.alu_rob_idx != '0;
  assign nxt = acc ? '{v: 1'b1, src: b.alu_rob_idx, val: res, jump: jmp, tgt: tgt} : '0;
  always_ff @(posedge clk) begin
    if (rst || b.alu_rb) st <= '{default: '0};
    else if (rdy) begin
      st[0] <= nxt;
      for (int k = 1; k < PIPE_STAGES; k++) st[k] <= st[k-1];
    end
  end
  assign b.cdb_alu_valid = st[PIPE_STAGES-1].v;
  assign b.cdb_alu_src   = st[PIPE_STAGES-1].src;
  assign b.cdb_alu_val   = st[PIPE_STAGES-1].val;
  assign b.cdb_alu_jump  = st[PIPE_STAGES-1].jump;
  assign b.cdb_alu_tgt   = st[PIPE_STAGES-1].tgt;
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed checks of alu_exec with one- and two-stage instances driven in lockstep
module tb_alu_exec;
  import alu_exec_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  int tests = 0;
  int fails = 0;
  alu_exec_if b1 ();
  alu_exec_if b2 ();
  alu_exec #(.PIPE_STAGES(1)) dut1 (.clk(clk), .rst(rst), .rdy(rdy), .b(b1));
  alu_exec #(.PIPE_STAGES(2)) dut2 (.clk(clk), .rst(rst), .rdy(rdy), .b(b2));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic ena, input logic [OPT_W-1:0] opt, input logic [31:0] v1,
                       input logic [31:0] v2, input logic [31:0] imm, input logic [ROB_W-1:0] idx);
    b1.alu_ena = ena; b1.alu_opt = opt; b1.alu_val1 = v1; b1.alu_val2 = v2; b1.alu_imm = imm; b1.alu_rob_idx = idx;
    b2.alu_ena = ena; b2.alu_opt = opt; b2.alu_val1 = v1; b2.alu_val2 = v2; b2.alu_imm = imm; b2.alu_rob_idx = idx;
  endtask
  task automatic idle();
    drive(1'b0, OPT_NONE, 32'd0, 32'd0, 32'd0, '0);
  endtask
  task automatic set_rb(input logic v);
    b1.alu_rb = v;
    b2.alu_rb = v;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask
  task automatic chk_cdb(input string tag, input logic v, input logic [ROB_W-1:0] src,
                         input logic [31:0] val, input logic j, input logic [31:0] tgt);
    chk({tag, ".valid"}, {31'd0, b1.cdb_alu_valid}, {31'd0, v});
    chk({tag, ".src"}, {28'd0, b1.cdb_alu_src}, {28'd0, src});
    chk({tag, ".val"}, b1.cdb_alu_val, val);
    chk({tag, ".jump"}, {31'd0, b1.cdb_alu_jump}, {31'd0, j});
    chk({tag, ".tgt"}, b1.cdb_alu_tgt, tgt);
  endtask
  initial begin
    set_rb(1'b0);
    idle();
    tick(); tick();
    rst = 1'b0;
    chk_cdb("reset", 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
    chk("reset.v2", {31'd0, b2.cdb_alu_valid}, 32'd0);
    // ADD 7 + (-6) = 1
    drive(1'b1, OPT_ADD, 32'd7, 32'hFFFF_FFFA, 32'd0, 4'd3);
    tick(); idle();
    chk_cdb("add", 1'b1, 4'd3, 32'd1, 1'b0, 32'd0);
    chk("add.v2_early", {31'd0, b2.cdb_alu_valid}, 32'd0);
    tick();
    chk("add.drop", {31'd0, b1.cdb_alu_valid}, 32'd0);
    chk("add.v2", {31'd0, b2.cdb_alu_valid}, 32'd1);
    chk("add.v2_val", b2.cdb_alu_val, 32'd1);
    chk("add.v2_src", {28'd0, b2.cdb_alu_src}, 32'd3);
    tick();
    chk("add.v2_drop", {31'd0, b2.cdb_alu_valid}, 32'd0);
    // back-to-back SRA (shamt 33 -> 1) then SLTU
    drive(1'b1, OPT_SRA, 32'h8000_0000, 32'd33, 32'd0, 4'd1);
    tick();
    drive(1'b1, OPT_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 4'd2);
    chk_cdb("sra", 1'b1, 4'd1, 32'hC000_0000, 1'b0, 32'd0);
    tick(); idle();
    chk_cdb("sltu", 1'b1, 4'd2, 32'd1, 1'b0, 32'd0);
    chk("sra.v2", b2.cdb_alu_val, 32'hC000_0000);
    tick();
    chk("b2b.drop", {31'd0, b1.cdb_alu_valid}, 32'd0);
    chk("sltu.v2", b2.cdb_alu_val, 32'd1);
    drive(1'b1, OPT_JALR, 32'h1001, 32'h200, 32'd4, 4'd5);
    tick();
    chk_cdb("jalr", 1'b1, 4'd5, 32'h204, 1'b1, 32'h1004);
    drive(1'b1, OPT_BLT, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd6);
    tick();
    chk_cdb("blt", 1'b1, 4'd6, 32'd0, 1'b1, 32'd0);
    drive(1'b1, OPT_BGEU, 32'd1, 32'd2, 32'd0, 4'd7);
    tick();
    chk_cdb("bgeu", 1'b1, 4'd7, 32'd0, 1'b0, 32'd0);
    drive(1'b1, OPT_SRAI, 32'hF000_0000, 32'd0, 32'd4, 4'd8);
    tick();
    chk_cdb("srai", 1'b1, 4'd8, 32'hFF00_0000, 1'b0, 32'd0);
    drive(1'b1, OPT_LUI, 32'd9, 32'd9, 32'h1234_5000, 4'd9);
    tick();
    chk_cdb("lui", 1'b1, 4'd9, 32'h1234_5000, 1'b0, 32'd0);
    drive(1'b1, OPT_JAL, 32'h100, 32'd0, 32'd0, 4'd10);
    tick();
    chk_cdb("jal", 1'b1, 4'd10, 32'h104, 1'b1, 32'd0);
    drive(1'b1, OPT_SUB, 32'd3, 32'd5, 32'd0, 4'd11);
    tick();
    chk_cdb("sub", 1'b1, 4'd11, 32'hFFFF_FFFE, 1'b0, 32'd0);
    drive(1'b1, 6'd63, 32'd5, 32'd5, 32'd5, 4'd12);
    tick(); idle();
    chk_cdb("unknown", 1'b1, 4'd12, 32'd0, 1'b0, 32'd0);
    tick(); tick();
    // rollback the cycle after issue: the two-stage op must never appear
    drive(1'b1, OPT_ADD, 32'd1, 32'd1, 32'd0, 4'd4);
    tick(); idle(); set_rb(1'b1);
    tick(); set_rb(1'b0);
    chk("rb.v2_0", {31'd0, b2.cdb_alu_valid}, 32'd0);
    chk("rb.v1_0", {31'd0, b1.cdb_alu_valid}, 32'd0);
    tick();
    chk("rb.v2_1", {31'd0, b2.cdb_alu_valid}, 32'd0);
    tick();
    chk("rb.v2_2", {31'd0, b2.cdb_alu_valid}, 32'd0);
    drive(1'b1, OPT_ADD, 32'd1, 32'd1, 32'd0, 4'd6); set_rb(1'b1);
    tick(); idle(); set_rb(1'b0);
    chk("rbena.v1", {31'd0, b1.cdb_alu_valid}, 32'd0);
    chk("rbena.v2_0", {31'd0, b2.cdb_alu_valid}, 32'd0);
    tick();
    chk("rbena.v2_1", {31'd0, b2.cdb_alu_valid}, 32'd0);
    // freeze with an op on the CDB
    drive(1'b1, OPT_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'd0, 4'd7);
    tick(); idle(); rdy = 1'b0;
    chk_cdb("frz.pre", 1'b1, 4'd7, 32'h0F0F_F0F0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cdb($sformatf("frz%0d", i), 1'b1, 4'd7, 32'h0F0F_F0F0, 1'b0, 32'd0);
      chk($sformatf("frz%0d.v2", i), {31'd0, b2.cdb_alu_valid}, 32'd0);
    end
    rdy = 1'b1;
    tick();
    chk("frz.drop", {31'd0, b1.cdb_alu_valid}, 32'd0);
    chk("frz.v2", {31'd0, b2.cdb_alu_valid}, 32'd1);
    chk("frz.v2_val", b2.cdb_alu_val, 32'h0F0F_F0F0);
    tick();
    chk("frz.v2_drop", {31'd0, b2.cdb_alu_valid}, 32'd0);
    drive(1'b1, OPT_ADD, 32'd1, 32'd1, 32'd0, 4'd0);
    tick(); idle();
    chk("idx0.v1", {31'd0, b1.cdb_alu_valid}, 32'd0);
    tick();
    chk("idx0.v2", {31'd0, b2.cdb_alu_valid}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
